// File: rtl/sevenseg_capture.sv
// -----------------------------------------------------------------------------
// sevenseg_capture
//
// Display monitor for a multiplexed, active-low, 4-digit seven-segment bus.
// Each cycle it samples the anode-select and cathode lines. It waits until a
// digit has been stable for SETTLE_CYCLES samples, then decodes the cathode
// pattern back to BCD. When all four positions have been captured, it
// converts the frame to binary and pulses frame_valid.
//
// Parameters:
//   SETTLE_CYCLES : identical consecutive samples needed before a capture
//                   (2..255)
//   CNT_W         : width of the stability counter and the error counter
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   anode_select in   [3:0] active-low digit enable, bit3 = thousands
//   LED_out      in   [6:0] active-low cathodes, bit6..bit0 = segments a..g
//   value        out  [13:0] binary value of the last completed frame
//   digits       out  [15:0] BCD of the last frame, [15:12] = thousands
//   blank_mask   out  [3:0] set bits mark blank positions in the last frame
//   frame_valid  out  one-cycle pulse when value/digits/blank_mask update
//   seg_error    out  one-cycle pulse after capturing an undecodable pattern
//   error_count  out  [CNT_W-1:0] saturating count of seg_error pulses
// -----------------------------------------------------------------------------
module sevenseg_capture #(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       anode_select,
  input  logic [6:0]       LED_out,
  output logic [13:0]      value,
  output logic [15:0]      digits,
  output logic [3:0]       blank_mask,
  output logic             frame_valid,
  output logic             seg_error,
  output logic [CNT_W-1:0] error_count
);

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] digit;
  } seg_dec_t;

  localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};
  localparam logic [13:0]      ACC_TEN   = 14'd10;

  // True when exactly one anode is driven low.
  function automatic logic one_low(input logic [3:0] an);
    logic r;
    case (an)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Digit position selected by a one-low anode pattern.
  function automatic logic [1:0] an_pos(input logic [3:0] an);
    logic [1:0] r;
    case (an)
      4'b0111: r = 2'd3;
      4'b1011: r = 2'd2;
      4'b1101: r = 2'd1;
      4'b1110: r = 2'd0;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Active-low cathode pattern (a..g) back to BCD. All segments off means blank.
  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t r;
    case (seg)
      7'b0000001: r = '{valid: 1'b1, blank: 1'b0, digit: 4'd0};
      7'b1001111: r = '{valid: 1'b1, blank: 1'b0, digit: 4'd1};
      7'b0010010: r = '{valid: 1'b1, blank: 1'b0, digit: 4'd2};
      7'b0000110: r = '{valid: 1'b1, blank: 1'b0, digit: 4'd3};
      7'b1001100: r = '{valid: 1'b1, blank: 1'b0, digit: 4'd4};
      7'b0100100: r = '{valid: 1'b1, blank: 1'b0, digit: 4'd5};
      7'b0100000: r = '{valid: 1'b1, blank: 1'b0, digit: 4'd6};
      7'b0001111: r = '{valid: 1'b1, blank: 1'b0, digit: 4'd7};
      7'b0000000: r = '{valid: 1'b1, blank: 1'b0, digit: 4'd8};
      7'b0000100: r = '{valid: 1'b1, blank: 1'b0, digit: 4'd9};
      7'b1111111: r = '{valid: 1'b1, blank: 1'b1, digit: 4'd0};
      default:    r = '{valid: 1'b0, blank: 1'b0, digit: 4'd0};
    endcase
    return r;
  endfunction

  // Input sample registers and the previous sample.
  logic [3:0]       an_q, an_d, an_p_q, an_p_d;
  logic [6:0]       seg_q, seg_d, seg_p_q, seg_p_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;

  // Working frame, built up as digits are captured.
  logic [3:0][3:0]  work_digit_q, work_digit_d;
  logic [3:0]       work_blank_q, work_blank_d;
  logic [3:0]       seen_q, seen_d;
  logic             seg_error_q, seg_error_d;
  logic [CNT_W-1:0] error_count_q, error_count_d;

  // Conversion state and the published outputs.
  state_e           state_q, state_d;
  logic [3:0][3:0]  snap_digit_q, snap_digit_d;
  logic [3:0]       snap_blank_q, snap_blank_d;
  logic [13:0]      acc_q, acc_d;
  logic [1:0]       idx_q, idx_d;
  logic [13:0]      value_q, value_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       blank_mask_q, blank_mask_d;
  logic             frame_valid_q, frame_valid_d;

  logic             stable_s;
  logic             capture_s;
  logic             start_s;
  logic [1:0]       pos_s;
  seg_dec_t         dec_s;
  logic [13:0]      acc_step_s;

  // Input pipeline and stability counter.
  always_comb begin
    an_d     = anode_select;
    seg_d    = LED_out;
    an_p_d   = an_q;
    seg_p_d  = seg_q;
    stable_s = (an_q == an_p_q) && (seg_q == seg_p_q) && one_low(an_q);
    pos_s    = an_pos(an_q);
    dec_s    = seg_decode(seg_q);
    if (!stable_s) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q == SETTLE_C) begin
      stable_cnt_d = stable_cnt_q;
    end else begin
      stable_cnt_d = stable_cnt_q + CNT_ONE;
    end
    // Fires only on the SETTLE-1 -> SETTLE step, so once per stable window.
    capture_s = stable_s && (stable_cnt_q == SETTLE_M1);
  end

  // Frame completion test, evaluated in SCAN only.
  always_comb begin
    start_s = (state_q == SCAN) && (seen_q == 4'b1111);
  end

  // Working-frame update and error reporting on each capture.
  always_comb begin
    work_digit_d  = work_digit_q;
    work_blank_d  = work_blank_q;
    error_count_d = error_count_q;
    seg_error_d   = 1'b0;
    // A completed frame releases the seen bits for the next one.
    if (start_s) begin
      seen_d = 4'b0000;
    end else begin
      seen_d = seen_q;
    end
    if (capture_s) begin
      if (dec_s.valid) begin
        work_digit_d[pos_s] = dec_s.digit;
        work_blank_d[pos_s] = dec_s.blank;
        seen_d[pos_s]       = 1'b1;
      end else begin
        seg_error_d = 1'b1;
        if (error_count_q != ERR_MAX) begin
          error_count_d = error_count_q + CNT_ONE;
        end else begin
          error_count_d = error_count_q;
        end
      end
    end else begin
      seg_error_d = 1'b0;
    end
  end

  // Snapshot, BCD-to-binary conversion (thousands first) and output publish.
  always_comb begin
    state_d       = state_q;
    snap_digit_d  = snap_digit_q;
    snap_blank_d  = snap_blank_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    value_d       = value_q;
    digits_d      = digits_q;
    blank_mask_d  = blank_mask_q;
    frame_valid_d = 1'b0;
    // Horner step; 9999 is the largest result, so 14 bits never overflow.
    acc_step_s    = (acc_q * ACC_TEN) + {10'd0, snap_digit_q[idx_q]};
    case (state_q)
      SCAN: begin
        if (start_s) begin
          snap_digit_d = work_digit_q;
          snap_blank_d = work_blank_q;
          acc_d        = 14'd0;
          idx_d        = 2'd3;
          state_d      = CONV;
        end else begin
          state_d = SCAN;
        end
      end
      CONV: begin
        acc_d = acc_step_s;
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          value_d       = acc_step_s;
          digits_d      = snap_digit_q;
          blank_mask_d  = snap_blank_q;
          frame_valid_d = 1'b1;
          state_d       = DONE;
        end else begin
          state_d = CONV;
        end
      end
      DONE: begin
        frame_valid_d = 1'b0;
        state_d       = SCAN;
      end
      default: begin
        frame_valid_d = 1'b0;
        state_d       = SCAN;
      end
    endcase
  end

  // Input sample and stability registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q         <= 4'd0;
      seg_q        <= 7'd0;
      an_p_q       <= 4'd0;
      seg_p_q      <= 7'd0;
      stable_cnt_q <= '0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      an_p_q       <= an_p_d;
      seg_p_q      <= seg_p_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  // Working-frame and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_digit_q  <= 16'd0;
      work_blank_q  <= 4'd0;
      seen_q        <= 4'd0;
      seg_error_q   <= 1'b0;
      error_count_q <= '0;
    end else begin
      work_digit_q  <= work_digit_d;
      work_blank_q  <= work_blank_d;
      seen_q        <= seen_d;
      seg_error_q   <= seg_error_d;
      error_count_q <= error_count_d;
    end
  end

  // Conversion FSM and published output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SCAN;
      snap_digit_q  <= 16'd0;
      snap_blank_q  <= 4'd0;
      acc_q         <= 14'd0;
      idx_q         <= 2'd0;
      value_q       <= 14'd0;
      digits_q      <= 16'd0;
      blank_mask_q  <= 4'd0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      snap_digit_q  <= snap_digit_d;
      snap_blank_q  <= snap_blank_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      value_q       <= value_d;
      digits_q      <= digits_d;
      blank_mask_q  <= blank_mask_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign value       = value_q;
  assign digits      = digits_q;
  assign blank_mask  = blank_mask_q;
  assign frame_valid = frame_valid_q;
  assign seg_error   = seg_error_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_capture
//
// Drives sevenseg_capture like a multiplexed display would, with directed
// scenarios followed by randomized frames (gaps, invalid patterns, glitches).
// A reference model tracks the displayed digits and the error tally. Frames
// are taken from the DUT by a negedge monitor and compared to the model.
// -----------------------------------------------------------------------------
module tb_sevenseg_capture;

  localparam int SETTLE = 4;
  localparam int PERIOD = 20;
  localparam int LAT    = SETTLE + 7;  // pos0 drive -> frame_valid sample

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode_select;
  logic [6:0]  LED_out;
  logic [13:0] value;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic        frame_valid;
  logic        seg_error;
  logic [7:0]  error_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int seg_pulses = 0;
  int drv_cyc = 0;
  int p0_cyc = 0;

  // Reference model state.
  int       m_dig [4];
  logic [3:0] m_blank;
  int       m_errcnt = 0;
  int       m_pulses = 0;

  int         fr_cyc [$];
  logic [13:0] fr_val [$];
  logic [15:0] fr_dig [$];
  logic [3:0]  fr_blk [$];

  sevenseg_capture #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .anode_select (anode_select),
    .LED_out      (LED_out),
    .value        (value),
    .digits       (digits),
    .blank_mask   (blank_mask),
    .frame_valid  (frame_valid),
    .seg_error    (seg_error),
    .error_count  (error_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record each published frame and count seg_error pulses.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fr_cyc.push_back(cyc);
      fr_val.push_back(value);
      fr_dig.push_back(digits);
      fr_blk.push_back(blank_mask);
    end
    if (seg_error === 1'b1) seg_pulses <= seg_pulses + 1;
  end

  // Symbol 0..9 is a digit, 10 is blank.
  function automatic logic [6:0] seg_of(input int sym);
    logic [6:0] r;
    case (sym)
      0: r = 7'b0000001;
      1: r = 7'b1001111;
      2: r = 7'b0010010;
      3: r = 7'b0000110;
      4: r = 7'b1001100;
      5: r = 7'b0100100;
      6: r = 7'b0100000;
      7: r = 7'b0001111;
      8: r = 7'b0000000;
      9: r = 7'b0000100;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] an_of(input int pos);
    logic [3:0] r;
    r = 4'b1111;
    r[pos] = 1'b0;
    return r;
  endfunction

  function automatic bit is_legal(input logic [6:0] p);
    for (int s = 0; s <= 10; s++) if (seg_of(s) == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold one bus state for n cycles, starting at a negedge.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    anode_select = an;
    LED_out      = seg;
    drv_cyc      = cyc;
    repeat (n) @(negedge clk);
  endtask

  // Display a valid symbol and record it in the model.
  task automatic put(input int pos, input int sym, input int n);
    drive(an_of(pos), seg_of(sym), n);
    if (pos == 0) p0_cyc = drv_cyc;
    m_dig[pos]   = (sym == 10) ? 0 : sym;
    m_blank[pos] = (sym == 10);
  endtask

  // Display an undecodable pattern long enough to be captured.
  task automatic put_bad(input int pos, input logic [6:0] pat);
    drive(an_of(pos), pat, PERIOD);
    m_pulses++;
    if (m_errcnt < 255) m_errcnt++;
  endtask

  task automatic check_frame(input string tag);
    int          ev;
    logic [15:0] ed;
    int          c;
    ev = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
    ed = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
    chk({tag, ".frames"}, fr_cyc.size(), 1);
    if (fr_cyc.size() > 0) begin
      c = fr_cyc.pop_front();
      chk({tag, ".value"}, 32'(fr_val.pop_front()), ev);
      chk({tag, ".digits"}, 32'(fr_dig.pop_front()), 32'(ed));
      chk({tag, ".blank"}, 32'(fr_blk.pop_front()), 32'(m_blank));
      chk({tag, ".latency"}, c - p0_cyc, LAT);
    end
    chk({tag, ".err_cnt"}, 32'(error_count), m_errcnt);
    chk({tag, ".err_pulses"}, seg_pulses, m_pulses);
    fr_cyc.delete(); fr_val.delete(); fr_dig.delete(); fr_blk.delete();
  endtask

  initial begin
    logic [6:0] pat;
    logic [3:0] an;
    int         sym;
    int         gl;
    string      tag;

    reset        = 1'b1;
    anode_select = 4'b1111;
    LED_out      = 7'b1111111;
    m_blank      = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst.value", 32'(value), 0);
    chk("rst.digits", 32'(digits), 0);
    chk("rst.blank", 32'(blank_mask), 0);
    chk("rst.fv", 32'(frame_valid), 0);
    chk("rst.seg_error", 32'(seg_error), 0);
    chk("rst.err_cnt", 32'(error_count), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1,2,3,4
    put(3, 1, PERIOD); put(2, 2, PERIOD); put(1, 3, PERIOD);
    chk("f1234.early", fr_cyc.size(), 0);
    put(0, 4, PERIOD);
    chk("f1234.hex", 32'(value), 32'h04D2);
    check_frame("f1234");

    // blank, blank, 4, 2 then 9999
    put(3, 10, PERIOD); put(2, 10, PERIOD); put(1, 4, PERIOD); put(0, 2, PERIOD);
    check_frame("f42");
    put(3, 9, PERIOD); put(2, 9, PERIOD); put(1, 9, PERIOD); put(0, 9, PERIOD);
    chk("f9999.hex", 32'(value), 32'h270F);
    check_frame("f9999");

    // undecodable pattern on pos1, then a valid 5
    put(3, 0, PERIOD); put(2, 6, PERIOD);
    put_bad(1, 7'b1111110);
    chk("bad.err_cnt", 32'(error_count), 1);
    chk("bad.pulses", seg_pulses, 1);
    chk("bad.no_frame", fr_cyc.size(), 0);
    put(1, 5, PERIOD); put(0, 8, PERIOD);
    check_frame("fbad");

    // short glitch (8) inside a stable 7 window on pos2
    put(3, 3, PERIOD);
    put(2, 7, 10);
    drive(an_of(2), 7'b0000000, 3);
    put(2, 7, 12);
    put(1, 1, PERIOD); put(0, 0, PERIOD);
    check_frame("fglitch");

    // idle and multi-low anodes between digits
    put(3, 5, PERIOD);
    drive(4'b1111, 7'b0000000, 6);
    put(2, 6, PERIOD);
    drive(4'b0011, 7'b0010010, 6);
    put(1, 7, PERIOD);
    drive(4'b1111, 7'b1001111, 4);
    put(0, 8, PERIOD);
    check_frame("fgap");

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      for (int p = 3; p >= 0; p--) begin
        case ($urandom_range(0, 2))
          1: drive(4'b1111, 7'($urandom_range(0, 127)), $urandom_range(1, 8));
          2: begin
            do an = 4'($urandom_range(0, 15)); while ($countones(an) > 2);
            drive(an, 7'($urandom_range(0, 127)), $urandom_range(1, 8));
          end
          default: ;
        endcase
        if ($urandom_range(0, 3) == 0) begin
          do pat = 7'($urandom_range(0, 127)); while (is_legal(pat));
          put_bad(p, pat);
        end
        sym = $urandom_range(0, 10);
        if (p > 0 && $urandom_range(0, 3) == 0) begin
          put(p, sym, 12);
          do pat = 7'($urandom_range(0, 127)); while (pat == seg_of(sym));
          gl = $urandom_range(1, SETTLE - 1);
          drive(an_of(p), pat, gl);
          put(p, sym, 12);
        end else begin
          put(p, sym, PERIOD);
        end
      end
      tag = $sformatf("rnd%0d", f);
      check_frame(tag);
    end

    // reset during conversion
    put(3, 2, PERIOD); put(2, 4, PERIOD); put(1, 6, PERIOD);
    anode_select = an_of(0);
    LED_out      = seg_of(8);
    repeat (8) @(negedge clk);
    reset        = 1'b1;
    anode_select = 4'b1111;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    m_errcnt = 0;
    repeat (6) @(negedge clk);
    chk("rstc.no_frame", fr_cyc.size(), 0);
    chk("rstc.value", 32'(value), 0);
    chk("rstc.digits", 32'(digits), 0);
    chk("rstc.blank", 32'(blank_mask), 0);
    chk("rstc.err_cnt", 32'(error_count), 0);
    put(3, 8, PERIOD); put(2, 10, PERIOD); put(1, 0, PERIOD); put(0, 3, PERIOD);
    check_frame("fpost");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
Receive-side counterpart of the team's multiplexed 4-digit seven-segment driver. The block samples the active-low anode-select and cathode buses, waits for each digit to settle, and decodes each cathode pattern back to BCD. Once all four positions are captured, it converts the frame to binary and pulses frame_valid. It sits in the loopback/self-check path and in benches as a display monitor.

Parameters:
SETTLE_CYCLES, 16, consecutive identical samples required before a digit is captured (legal range 2..255).
CNT_W, 8, width of the stability counter and the error counter.

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-high reset
anode_select  input  4  active-low digit enable; bit3 = thousands, bit0 = units
LED_out  input  7  active-low cathodes, bit6..bit0 = segments a..g
value  output  14  binary value of the last completed frame (0..9999)
digits  output  16  BCD of the last frame, [15:12] = thousands .. [3:0] = units
blank_mask  output  4  bit set = that position was blank (1111111) in the last frame
frame_valid  output  1  one-cycle pulse when value, digits and blank_mask update
seg_error  output  1  one-cycle pulse on capture of an undecodable pattern
error_count  output  8  saturating count of seg_error pulses

Behaviour:
- Reset (async, high): all outputs 0, all internal registers 0, state SCAN.
- Input stage: anode_select and LED_out are registered once each cycle into an_q and seg_q. The previous sample is kept in an_p and seg_p.
- Stability counter (stable_cnt):
  - Cleared to 0 when {an_q,seg_q} != {an_p,seg_p}.
  - Also cleared to 0 when an_q is not exactly one bit low (1111 or multiple low).
  - Otherwise increments, saturating at SETTLE_CYCLES.
- Capture strobe: fires on the single edge where stable_cnt goes SETTLE_CYCLES-1 -> SETTLE_CYCLES. This is exactly once per stable window. Glitches shorter than SETTLE_CYCLES are never captured.
- Position map: 0111 -> pos3, 1011 -> pos2, 1101 -> pos1, 1110 -> pos0.
- Cathode decode:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - 1111111 = blank: digit 0, blank bit set.
  - Any other pattern is invalid: seg_error pulses the cycle after capture, error_count increments (saturating at 255), and the working digit and seen bit for that position are unchanged.
- Valid capture: writes work_digit[pos] and work_blank[pos], and sets seen[pos]. Recapturing an already-seen position overwrites it (latest wins).
- FSM states:
  - SCAN: when a capture makes seen == 1111 (capture edge C), at edge C+1: snapshot <- work regs, seen <- 0, acc <- 0, idx <- 3, state -> CONV.
  - CONV: edges C+2..C+5: acc <- acc*10 + snap_digit[idx], idx decrements. After the idx=0 step (edge C+5): value <- acc result, digits <- snapshot, blank_mask <- snap_blank, frame_valid <- 1, state -> DONE.
  - DONE: at edge C+6: frame_valid <- 0, state -> SCAN.
- Latency: frame_valid is high for exactly the cycle between edges C+5 and C+6.
- Concurrency: capture continues in CONV/DONE into the work registers. SETTLE_CYCLES >= 2 guarantees the next frame cannot complete before SCAN is re-entered.
- Width: acc is 14 bits. Worst case 9*1000+9*100+9*10+9 = 9999 fits, so there is no overflow path.
- Reset mid-CONV/DONE: async clear, so no frame_valid is emitted, outputs return to 0, and the partial frame is discarded.
- value, digits and blank_mask hold between frames.

Test Plan:
- SETTLE_CYCLES=4, digit period 20 cycles, scan 1,2,3,4 (pos3..pos0) -> one frame_valid pulse; value=1234 (14'h04D2), digits=16'h1234, blank_mask=0000; pulse lands 5 edges after the pos0 capture edge.
- Scan blank, blank, 4, 2 -> value=42, digits=16'h0042, blank_mask=1100; repeat 9,9,9,9 -> value=9999 (14'h270F).
- pos1 driven 1111110 for one period, then 5 -> seg_error pulses once, error_count=1, no frame until the valid 5 is captured, then value reflects the 5.
- 3-cycle glitch (pattern 0000000 on pos2) inside a stable 7 window with SETTLE_CYCLES=4 -> glitch not captured; stable_cnt restarts; digit 7 recaptured; no seg_error.
- Anode 1111 and 0011 inserted between digits -> no capture, no error; the frame still completes correctly.
- Assert reset at edge C+3 during CONV -> frame_valid never pulses; value=0, digits=0, error_count=0; the next complete scan yields a correct frame.
